oled_text_refresh: RTL and testbench

Character frame-buffer and refresh sequencer in front of `oled_cntrl`.

- Holds a 64-entry text buffer (4 rows × 16 characters) that user logic writes at random.
- Streams the whole buffer, one byte at a time, into the controller's `data` / `data_valid` / `done` handshake whenever the buffer is dirty.
- Sits between the SoC user logic and `oled_cntrl`, which then only sees well-paced full-frame character streams.

---
 rtl/oled_text_refresh.sv | 126 ++++++++++++
 tb/tb_oled_text_refresh.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_text_refresh.sv
// 4x16 character frame buffer that streams the whole buffer to oled_cntrl,
// one byte per data_valid/done handshake, whenever its contents change.
module oled_text_refresh #(
   parameter int CHARS          = 64,
   parameter int ADDR_W         = 6,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic              i_clk,
   input  logic              i_arst_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]        i_wr_char,
   input  logic              i_clear,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_timeout,
   output logic [7:0]        o_oled_data,
   output logic              o_oled_data_valid,
   input  logic              i_oled_done
);

   localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CHARS - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      CLEAR,
      WAIT_INIT,
      IDLE,
      FETCH,
      ISSUE,
      WAIT_DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [7:0]        buffer [CHARS];
   logic [ADDR_W-1:0] idx;
   logic              init_seen;
   logic              dirty;
   logic              clear_pend;
   logic [CNT_W-1:0]  wait_cnt;

   logic              wr_ok;
   logic              clear_last;
   logic              idle_clear;
   logic              idle_start;
   logic              char_done;
   logic              frame_last;
   logic              timeout_hit;

   always_comb begin
      wr_ok             = i_wr_en && (state != CLEAR) &&
                          ({1'b0, i_wr_addr} < (ADDR_W + 1)'(CHARS));
      clear_last        = (state == CLEAR) && (idx == LAST_IDX);
      idle_clear        = (state == IDLE) && (i_clear || clear_pend);
      idle_start        = (state == IDLE) && !i_clear && !clear_pend && dirty;
      char_done         = (state == WAIT_DONE) && i_oled_done;
      frame_last        = char_done && (idx == LAST_IDX);
      // a done arriving on the final count still completes the character
      timeout_hit       = (state == WAIT_DONE) && !i_oled_done && (wait_cnt == CNT_LAST);
      o_oled_data_valid = (state == ISSUE);
      o_busy            = (state != IDLE) && (state != WAIT_INIT);
      state_next        = state;
      unique case (state)
         CLEAR:     if (clear_last) state_next = init_seen ? IDLE : WAIT_INIT;
         WAIT_INIT: if (i_oled_done || init_seen) state_next = IDLE;
         IDLE: begin
            if (idle_clear)      state_next = CLEAR;
            else if (idle_start) state_next = FETCH;
         end
         FETCH:     state_next = ISSUE;
         ISSUE:     state_next = WAIT_DONE;
         WAIT_DONE: begin
            if (char_done)        state_next = frame_last ? IDLE : FETCH;
            else if (timeout_hit) state_next = IDLE;
         end
         default:   state_next = CLEAR;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) state <= CLEAR;
      else           state <= state_next;
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         idx          <= '0;
         init_seen    <= 1'b0;
         dirty        <= 1'b0;
         clear_pend   <= 1'b0;
         wait_cnt     <= '0;
         o_oled_data  <= '0;
         o_frame_done <= 1'b0;
         o_timeout    <= 1'b0;
      end else begin
         if (state == CLEAR)               idx <= clear_last ? '0 : idx + 1'b1;
         else if (idle_clear || idle_start) idx <= '0;
         else if (char_done && !frame_last) idx <= idx + 1'b1;

         if (i_oled_done && ((state == CLEAR) || (state == WAIT_INIT))) init_seen <= 1'b1;

         // a write landing on the frame-start cycle must win so it is not lost
         if (wr_ok || clear_last || timeout_hit) dirty <= 1'b1;
         else if (idle_start)                    dirty <= 1'b0;

         if (i_clear && (state != IDLE) && (state != CLEAR)) clear_pend <= 1'b1;
         else if (idle_clear)                                clear_pend <= 1'b0;

         if (state == ISSUE)                               wait_cnt <= '0;
         else if ((state == WAIT_DONE) && (wait_cnt != '1)) wait_cnt <= wait_cnt + 1'b1;

         if (state == FETCH) o_oled_data <= buffer[idx];

         o_frame_done <= frame_last;
         if (timeout_hit) o_timeout <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (state == CLEAR) buffer[idx]       <= 8'h20;
      else if (wr_ok)     buffer[i_wr_addr] <= i_wr_char;
   end

endmodule

// File: tb/tb_oled_text_refresh.sv
// Scoreboard bench for oled_text_refresh: expected frame bytes are queued by
// the stimulus, and a monitor checks every data_valid strobe against them.
module tb_oled_text_refresh;

   localparam int CHARS    = 64;
   localparam int ADDR_W   = 7;
   localparam int TIMEOUT  = 50;
   localparam int DONE_LAT = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [7:0]        wr_char = '0;
   logic              clear = 1'b0;
   logic              busy;
   logic              frame_done;
   logic              timeout;
   logic [7:0]        oled_data;
   logic              oled_valid;
   logic              oled_done = 1'b0;

   logic [7:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         frames = 0;
   int         cycle = 0;
   int         init_cycle = -1;
   int         countdown = 0;
   bit         done_en = 1'b1;

   always #5 clk = ~clk;

   oled_text_refresh #(
      .CHARS          (CHARS),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .i_clk             (clk),
      .i_arst_n          (rst_n),
      .i_wr_en           (wr_en),
      .i_wr_addr         (wr_addr),
      .i_wr_char         (wr_char),
      .i_clear           (clear),
      .o_busy            (busy),
      .o_frame_done      (frame_done),
      .o_timeout         (timeout),
      .o_oled_data       (oled_data),
      .o_oled_data_valid (oled_valid),
      .i_oled_done       (oled_done)
   );

   always @(posedge clk) cycle <= cycle + 1;

   // oled_cntrl model: one power-up done at init_cycle, then a done DONE_LAT
   // cycles after each accepted strobe
   always @(negedge clk) begin
      if (!rst_n) begin
         countdown = 0;
         oled_done = 1'b0;
      end else begin
         oled_done = 1'b0;
         if (countdown > 0) begin
            countdown = countdown - 1;
            if (countdown == 0) oled_done = 1'b1;
         end
         if (oled_valid && done_en) countdown = DONE_LAT;
         if (cycle == init_cycle) oled_done = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (oled_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL strobe_unexpected got %02h expected no strobe", oled_data);
            end else begin
               automatic logic [7:0] e = exp_q.pop_front();
               if (oled_data !== e) begin
                  errors++;
                  $display("FAIL strobe_data got %02h expected %02h", oled_data, e);
               end
            end
         end
         if (frame_done) frames++;
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_frame(input int a1, input logic [7:0] c1,
                             input int a2, input logic [7:0] c2);
      for (int i = 0; i < CHARS; i++)
         exp_q.push_back(i == a1 ? c1 : (i == a2 ? c2 : 8'h20));
   endtask

   task automatic wr(input int a, input logic [7:0] c);
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_char = c;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic wait_valids(input int n, input string name);
      int seen = 0;
      for (int i = 0; i < 2000 && seen < n; i++) begin
         @(negedge clk);
         if (oled_valid) seen++;
      end
      if (seen < n) check(name, seen, n);
   endtask

   task automatic wait_frames(input int target, input string name);
      for (int i = 0; i < 4000 && frames < target; i++) @(negedge clk);
      check(name, frames, target);
   endtask

   task automatic busy_run(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"}, oled_data, 8'h00);
      check({tag, "_valid"}, oled_valid, 0);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_timeout"}, timeout, 0);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      int found;

      // reset, clear, power-up done, first all-blank frame
      push_frame(-1, 8'h00, -1, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n      = 1'b1;
      init_cycle = cycle + 100;
      busy_run(n);
      check("clear_len", n, CHARS);
      wait_frames(1, "frames_init");
      settle(60);
      check("frames_init_exact", frames, 1);
      check("queue_init", exp_q.size(), 0);

      // write to addr 10 while strobe 40 is in flight: old frame, then corrected frame
      push_frame(-1, 8'h00, -1, 8'h00);
      push_frame(10, 8'h42, -1, 8'h00);
      wr(0, 8'h20);
      wait_valids(41, "wait_strobe40");
      wr(10, 8'h42);
      wait_frames(3, "frames_midwrite");
      settle(60);
      check("frames_midwrite_exact", frames, 3);
      check("queue_midwrite", exp_q.size(), 0);

      // silent controller: 1 ISSUE cycle + TIMEOUT WAIT_DONE cycles, then retry
      done_en = 1'b0;
      exp_q.push_back(8'h20);
      wr(10, 8'h20);
      wait_valids(1, "wait_timeout_strobe");
      n = 0;
      while (!timeout && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("timeout_delay", n, TIMEOUT + 1);
      done_en = 1'b1;
      push_frame(-1, 8'h00, -1, 8'h00);
      wait_frames(4, "frames_retry");
      settle(60);
      check("frames_retry_exact", frames, 4);
      check("timeout_sticky", timeout, 1);
      check("queue_retry", exp_q.size(), 0);

      // clear mid-frame plus an out-of-range write
      push_frame(3, 8'h43, -1, 8'h00);
      push_frame(-1, 8'h00, -1, 8'h00);
      wr(3, 8'h43);
      wait_valids(20, "wait_strobe20");
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      wr(70, 8'h55);
      found = 0;
      for (int i = 0; i < 2000 && found == 0; i++) begin
         @(negedge clk);
         if (frame_done) found = 1;
      end
      check("clear_frame_done_seen", found, 1);
      busy_run(n);
      check("clear_pend_len", n, CHARS);
      wait_frames(6, "frames_clear");
      settle(100);
      check("frames_clear_exact", frames, 6);
      check("queue_clear", exp_q.size(), 0);

      // async reset during WAIT_DONE, then writes while waiting for power-up done
      push_frame(1, 8'h44, -1, 8'h00);
      wr(1, 8'h44);
      wait_valids(10, "wait_strobe10");
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      busy_run(n);
      check("reclear_len", n, CHARS);
      wr(5, 8'h41);
      wr(63, 8'h5A);
      push_frame(5, 8'h41, 63, 8'h5A);
      init_cycle = cycle + 5;
      wait_frames(7, "frames_az");
      settle(100);
      check("frames_az_exact", frames, 7);
      check("queue_az", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
